// File: rtl/clkrst_gen.sv
// clkrst_gen: divides the board oscillator, debounces the reset button and
// stretches the system reset so it releases on a divided-clock rising edge.
module clkrst_gen #(
  parameter int DIVIDE          = 4,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int RESET_HOLD      = 16
) (
  input  logic CLK,
  input  logic power_on_reset,
  input  logic btn_n,
  output logic clk,
  output logic clk_en,
  output logic btn_pressed,
  output logic sys_reset
);

  localparam int CNT_W  = $clog2(DIVIDE);
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIVIDE - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(DIVIDE / 2);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RESET_HOLD);

  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cntNext;
  logic              r_clk;
  logic              r_clkEn;
  logic              r_sync1;
  logic              r_sync2;
  logic              w_rawPressed;
  logic              r_btnPressed;
  logic              w_btnPressedNext;
  logic [DB_W-1:0]   r_dbCnt;
  logic [DB_W-1:0]   w_dbCntNext;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_holdNext;
  logic              r_sysReset;

  // Outputs come from the next count so clk/clk_en are clean registered edges.
  always_comb begin
    w_cntNext = r_cnt + 1'b1;
    if (r_cnt == CNT_LAST) begin
      w_cntNext = '0;
    end
  end

  always_ff @(posedge CLK or posedge power_on_reset) begin
    if (power_on_reset) begin
      r_cnt   <= CNT_LAST;
      r_clk   <= 1'b0;
      r_clkEn <= 1'b0;
    end else begin
      r_cnt   <= w_cntNext;
      r_clk   <= (w_cntNext < CNT_HALF);
      r_clkEn <= (w_cntNext == CNT_LAST);
    end
  end

  always_ff @(posedge CLK or posedge power_on_reset) begin
    if (power_on_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rawPressed = ~r_sync2;

  // Any sample agreeing with the accepted level restarts the stability run.
  always_comb begin
    w_btnPressedNext = r_btnPressed;
    w_dbCntNext      = '0;
    if (w_rawPressed != r_btnPressed) begin
      if (r_dbCnt == DB_LAST) begin
        w_btnPressedNext = ~r_btnPressed;
      end else begin
        w_dbCntNext = r_dbCnt + 1'b1;
      end
    end
  end

  // A press reloads the hold even when it coincides with a clk_en pulse.
  always_comb begin
    w_holdNext = r_hold;
    if (w_btnPressedNext) begin
      w_holdNext = HOLD_MAX;
    end else if (r_clkEn && (r_hold != '0)) begin
      w_holdNext = r_hold - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge power_on_reset) begin
    if (power_on_reset) begin
      r_btnPressed <= 1'b0;
      r_dbCnt      <= '0;
      r_hold       <= HOLD_MAX;
      r_sysReset   <= 1'b1;
    end else begin
      r_btnPressed <= w_btnPressedNext;
      r_dbCnt      <= w_dbCntNext;
      r_hold       <= w_holdNext;
      r_sysReset   <= w_btnPressedNext | (w_holdNext != '0);
    end
  end

  assign clk         = r_clk;
  assign clk_en      = r_clkEn;
  assign btn_pressed = r_btnPressed;
  assign sys_reset   = r_sysReset;

endmodule

// File: tb/tb_clkrst_gen.sv
// tb_clkrst_gen: directed scenarios for clkrst_gen with hand-derived edge
// numbers (edge 1 is the first CLK rising edge after reset release).
module tb_clkrst_gen;

  logic CLK          = 1'b0;
  logic powerOnReset = 1'b0;
  logic btnN         = 1'b1;
  logic clkOut, clkEn, btnPressed, sysReset;
  logic clk5, clkEn5, btnPressed5, sysReset5;

  int checks   = 0;
  int failures = 0;
  int edgeN    = 0;

  always #5 CLK = ~CLK;

  clkrst_gen #(.DIVIDE(4), .DEBOUNCE_CYCLES(4), .RESET_HOLD(2)) dut (
    .CLK(CLK), .power_on_reset(powerOnReset), .btn_n(btnN),
    .clk(clkOut), .clk_en(clkEn), .btn_pressed(btnPressed), .sys_reset(sysReset)
  );

  clkrst_gen #(.DIVIDE(5), .DEBOUNCE_CYCLES(4), .RESET_HOLD(2)) dut5 (
    .CLK(CLK), .power_on_reset(powerOnReset), .btn_n(btnN),
    .clk(clk5), .clk_en(clkEn5), .btn_pressed(btnPressed5), .sys_reset(sysReset5)
  );

  task automatic step();
    @(posedge CLK);
    #1;
    edgeN++;
  endtask

  task automatic stepTo(input int n);
    while (edgeN < n) step();
  endtask

  task automatic do_reset();
    powerOnReset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    powerOnReset = 1'b0;
    edgeN = 0;
  endtask

  task automatic test_reset();
    #2 powerOnReset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (clkOut !== 1'b0) begin $display("[TB] FAIL reset_clk got=%b exp=0", clkOut); failures++; end
    checks++; if (clkEn !== 1'b0) begin $display("[TB] FAIL reset_clk_en got=%b exp=0", clkEn); failures++; end
    checks++; if (btnPressed !== 1'b0) begin $display("[TB] FAIL reset_btn_pressed got=%b exp=0", btnPressed); failures++; end
    checks++; if (sysReset !== 1'b1) begin $display("[TB] FAIL reset_sys_reset got=%b exp=1", sysReset); failures++; end
  endtask

  task automatic test_power_on();
    logic expClk, expEn, expRst;
    do_reset();
    for (int n = 1; n <= 12; n++) begin
      step();
      expClk = ((n - 1) % 4) < 2;
      expEn  = (n % 4) == 0;
      expRst = n < 9;
      checks++; if (clkOut !== expClk) begin $display("[TB] FAIL power_on_clk edge=%0d got=%b exp=%b", n, clkOut, expClk); failures++; end
      checks++; if (clkEn !== expEn) begin $display("[TB] FAIL power_on_clk_en edge=%0d got=%b exp=%b", n, clkEn, expEn); failures++; end
      checks++; if (sysReset !== expRst) begin $display("[TB] FAIL power_on_sys_reset edge=%0d got=%b exp=%b", n, sysReset, expRst); failures++; end
    end
  endtask

  task automatic test_odd_divide();
    logic expClk, expEn, expRst;
    do_reset();
    for (int n = 1; n <= 12; n++) begin
      step();
      expClk = ((n - 1) % 5) < 2;
      expEn  = (n % 5) == 0;
      expRst = n < 11;
      checks++; if (clk5 !== expClk) begin $display("[TB] FAIL odd_clk edge=%0d got=%b exp=%b", n, clk5, expClk); failures++; end
      checks++; if (clkEn5 !== expEn) begin $display("[TB] FAIL odd_clk_en edge=%0d got=%b exp=%b", n, clkEn5, expEn); failures++; end
      checks++; if (sysReset5 !== expRst) begin $display("[TB] FAIL odd_sys_reset edge=%0d got=%b exp=%b", n, sysReset5, expRst); failures++; end
      checks++; if (btnPressed5 !== 1'b0) begin $display("[TB] FAIL odd_btn_pressed edge=%0d got=%b exp=0", n, btnPressed5); failures++; end
    end
  endtask

  task automatic test_clean_press();
    logic expPressed, expRst;
    do_reset();
    stepTo(19);
    btnN = 1'b0;
    for (int n = 20; n <= 52; n++) begin
      step();
      expPressed = (n >= 25) && (n < 45);
      expRst     = (n >= 25) && (n < 49);
      checks++; if (btnPressed !== expPressed) begin $display("[TB] FAIL press_btn_pressed edge=%0d got=%b exp=%b", n, btnPressed, expPressed); failures++; end
      checks++; if (sysReset !== expRst) begin $display("[TB] FAIL press_sys_reset edge=%0d got=%b exp=%b", n, sysReset, expRst); failures++; end
      if (n == 49) begin
        checks++; if (clkOut !== 1'b1) begin $display("[TB] FAIL press_release_on_clk_rise got=%b exp=1", clkOut); failures++; end
      end
      if (n == 39) btnN = 1'b1;
    end
  endtask

  task automatic test_bounce();
    do_reset();
    stepTo(19);
    for (int rep = 0; rep < 5; rep++) begin
      for (int i = 0; i < 4; i++) begin
        btnN = (i == 3);
        step();
        checks++; if (btnPressed !== 1'b0) begin $display("[TB] FAIL bounce_btn_pressed edge=%0d got=%b exp=0", edgeN, btnPressed); failures++; end
        checks++; if (sysReset !== 1'b0) begin $display("[TB] FAIL bounce_sys_reset edge=%0d got=%b exp=0", edgeN, sysReset); failures++; end
      end
    end
    btnN = 1'b1;
    repeat (6) begin
      step();
      checks++; if (btnPressed !== 1'b0) begin $display("[TB] FAIL bounce_settle edge=%0d got=%b exp=0", edgeN, btnPressed); failures++; end
    end
  endtask

  task automatic test_back_to_back();
    logic expPressed, expRst;
    do_reset();
    stepTo(19);
    btnN = 1'b0;
    for (int n = 20; n <= 64; n++) begin
      step();
      expPressed = ((n >= 25) && (n < 45)) || ((n >= 49) && (n < 57));
      expRst     = (n >= 25) && (n < 61);
      checks++; if (btnPressed !== expPressed) begin $display("[TB] FAIL repress_btn_pressed edge=%0d got=%b exp=%b", n, btnPressed, expPressed); failures++; end
      checks++; if (sysReset !== expRst) begin $display("[TB] FAIL repress_sys_reset edge=%0d got=%b exp=%b", n, sysReset, expRst); failures++; end
      if (n == 39) btnN = 1'b1;
      if (n == 43) btnN = 1'b0;
      if (n == 51) btnN = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    logic expPressed;
    do_reset();
    stepTo(17);
    btnN = 1'b0;
    stepTo(21);
    checks++; if (clkOut !== 1'b1) begin $display("[TB] FAIL mid_pre_clk got=%b exp=1", clkOut); failures++; end
    checks++; if (sysReset !== 1'b0) begin $display("[TB] FAIL mid_pre_sys_reset got=%b exp=0", sysReset); failures++; end
    powerOnReset = 1'b1;
    #1;
    checks++; if (clkOut !== 1'b0) begin $display("[TB] FAIL mid_clk got=%b exp=0", clkOut); failures++; end
    checks++; if (clkEn !== 1'b0) begin $display("[TB] FAIL mid_clk_en got=%b exp=0", clkEn); failures++; end
    checks++; if (btnPressed !== 1'b0) begin $display("[TB] FAIL mid_btn_pressed got=%b exp=0", btnPressed); failures++; end
    checks++; if (sysReset !== 1'b1) begin $display("[TB] FAIL mid_sys_reset got=%b exp=1", sysReset); failures++; end
    repeat (2) @(posedge CLK);
    #1;
    powerOnReset = 1'b0;
    edgeN = 0;
    for (int n = 1; n <= 7; n++) begin
      step();
      expPressed = n >= 6;
      checks++; if (btnPressed !== expPressed) begin $display("[TB] FAIL mid_restart_btn_pressed edge=%0d got=%b exp=%b", n, btnPressed, expPressed); failures++; end
      checks++; if (sysReset !== 1'b1) begin $display("[TB] FAIL mid_restart_sys_reset edge=%0d got=%b exp=1", n, sysReset); failures++; end
    end
    btnN = 1'b1;
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_odd_divide();
    test_clean_press();
    test_bounce();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
